// File: rtl/sao_stat_bin_accum.sv
// Per-CTB SAO statistics accumulator: merges 4-pixel partial sums into
// per-category (sum, count) bins and streams them out at end of CTB.
module sao_stat_bin_accum #(
  parameter int diff_clip_bit = 4,
  parameter int n_pix = 4,
  parameter int n_bo_type = 5,
  parameter int sum_bit = 16,
  parameter int cnt_bit = 12
) (
  input  logic clk,
  input  logic arst,
  input  logic en,
  input  logic start,
  input  logic done,
  input  logic in_valid,
  input  logic [n_pix*n_bo_type-1:0] cate,
  input  logic [n_pix-1:0] b_use,
  input  logic signed [diff_clip_bit+2:0] s41,
  input  logic signed [diff_clip_bit+2:0] s31,
  input  logic signed [diff_clip_bit+1:0] s21,
  input  logic signed [diff_clip_bit:0] s11,
  output logic out_valid,
  input  logic out_ready,
  output logic [n_bo_type-1:0] out_idx,
  output logic signed [sum_bit-1:0] out_sum,
  output logic [cnt_bit-1:0] out_cnt,
  output logic out_last,
  output logic busy
);

  localparam int n_bin = 1 << n_bo_type;
  localparam logic signed [sum_bit:0] sum_hi = {2'b00, {(sum_bit-1){1'b1}}};
  localparam logic signed [sum_bit:0] sum_lo = {2'b11, {(sum_bit-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, ACCUM, DRAIN} state_t;

  state_t state, state_nx;
  logic [n_bo_type-1:0] idx, idx_nx;

  logic signed [sum_bit-1:0] bin_sum [n_bin];
  logic [cnt_bit-1:0] bin_cnt [n_bin];
  logic signed [sum_bit-1:0] nsum [n_bin];
  logic [cnt_bit-1:0] ncnt [n_bin];

  logic [n_bo_type-1:0] c [4];
  logic signed [sum_bit-1:0] ls [4];
  logic [2:0] lc [4];
  logic [3:0] lead;
  logic acc;

  assign acc = (state == ACCUM) && in_valid && en;

  // Leader detection ignores b_use: upstream sums already mask unused diffs.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      c[i] = cate[i*n_bo_type +: n_bo_type];
    end
    ls[0] = {{(sum_bit-diff_clip_bit-3){s41[diff_clip_bit+2]}}, s41};
    ls[1] = {{(sum_bit-diff_clip_bit-3){s31[diff_clip_bit+2]}}, s31};
    ls[2] = {{(sum_bit-diff_clip_bit-2){s21[diff_clip_bit+1]}}, s21};
    ls[3] = {{(sum_bit-diff_clip_bit-1){s11[diff_clip_bit]}}, s11};
    for (int i = 0; i < 4; i++) begin
      lead[i] = 1'b1;
      lc[i] = '0;
      for (int j = 0; j < i; j++) begin
        if (c[j] == c[i]) lead[i] = 1'b0;
      end
      for (int k = i; k < 4; k++) begin
        if (c[k] == c[i] && b_use[k]) lc[i] = lc[i] + 3'd1;
      end
    end
  end

  always_comb begin
    logic signed [sum_bit-1:0] asum;
    logic [2:0] acnt;
    logic signed [sum_bit:0] wsum;
    logic [cnt_bit:0] wcnt;
    asum = '0;
    acnt = '0;
    wsum = '0;
    wcnt = '0;
    for (int b = 0; b < n_bin; b++) begin
      asum = '0;
      acnt = '0;
      for (int i = 0; i < 4; i++) begin
        if (lead[i] && lc[i] != 3'd0 && c[i] == n_bo_type'(b)) begin
          asum = ls[i];
          acnt = lc[i];
        end
      end
      wsum = $signed({bin_sum[b][sum_bit-1], bin_sum[b]})
           + $signed({asum[sum_bit-1], asum});
      if (wsum > sum_hi) nsum[b] = sum_hi[sum_bit-1:0];
      else if (wsum < sum_lo) nsum[b] = sum_lo[sum_bit-1:0];
      else nsum[b] = wsum[sum_bit-1:0];
      wcnt = {1'b0, bin_cnt[b]} + {{(cnt_bit-2){1'b0}}, acnt};
      ncnt[b] = wcnt[cnt_bit] ? '1 : wcnt[cnt_bit-1:0];
    end
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      for (int b = 0; b < n_bin; b++) begin
        bin_sum[b] <= '0;
        bin_cnt[b] <= '0;
      end
    end else if (start) begin
      for (int b = 0; b < n_bin; b++) begin
        bin_sum[b] <= '0;
        bin_cnt[b] <= '0;
      end
    end else if (acc) begin
      for (int b = 0; b < n_bin; b++) begin
        bin_sum[b] <= nsum[b];
        bin_cnt[b] <= ncnt[b];
      end
    end
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      state <= IDLE;
      idx <= '0;
    end else begin
      state <= state_nx;
      idx <= idx_nx;
    end
  end

  always_comb begin
    state_nx = state;
    idx_nx = idx;
    if (start) begin
      state_nx = ACCUM;
      idx_nx = '0;
    end else begin
      unique case (state)
        ACCUM: begin
          if (done) begin
            state_nx = DRAIN;
            idx_nx = '0;
          end
        end
        DRAIN: begin
          if (out_ready) begin
            idx_nx = idx + 1'b1;
            if (idx == '1) state_nx = IDLE;
          end
        end
        default: ;
      endcase
    end
  end

  assign out_valid = (state == DRAIN);
  assign out_idx = idx;
  assign out_sum = bin_sum[idx];
  assign out_cnt = bin_cnt[idx];
  assign out_last = out_valid && (idx == '1);
  assign busy = (state != IDLE);

endmodule

// File: tb/tb_sao_stat_bin_accum.sv
// Scoreboard bench for sao_stat_bin_accum: directed groups, expected bins
// queued per drain, monitor compares each handshake beat.
module tb_sao_stat_bin_accum;

  logic clk = 1'b0;
  logic arst, en, start, done, in_valid, out_ready;
  logic [19:0] cate;
  logic [3:0] b_use;
  logic signed [6:0] s41, s31;
  logic signed [5:0] s21;
  logic signed [4:0] s11;
  logic out_valid, out_last, busy;
  logic [4:0] out_idx;
  logic signed [7:0] out_sum;
  logic [11:0] out_cnt;

  always #5 clk = ~clk;

  sao_stat_bin_accum #(
    .diff_clip_bit(4),
    .n_pix(4),
    .n_bo_type(5),
    .sum_bit(8),
    .cnt_bit(12)
  ) dut (
    .clk(clk),
    .arst(arst),
    .en(en),
    .start(start),
    .done(done),
    .in_valid(in_valid),
    .cate(cate),
    .b_use(b_use),
    .s41(s41),
    .s31(s31),
    .s21(s21),
    .s11(s11),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_idx(out_idx),
    .out_sum(out_sum),
    .out_cnt(out_cnt),
    .out_last(out_last),
    .busy(busy)
  );

  typedef struct {
    logic [4:0] idx;
    int sum;
    int cnt;
    logic last;
  } exp_t;

  exp_t exp_q[$];
  int es[32];
  int ec[32];
  int total = 0;
  int bad = 0;

  task automatic chk(input string nm, input longint act, input longint req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s act=%0d req=%0d", nm, act, req);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_exp();
    for (int b = 0; b < 32; b++) begin
      es[b] = 0;
      ec[b] = 0;
    end
  endtask

  task automatic push_drain();
    exp_t e;
    for (int b = 0; b < 32; b++) begin
      e.idx = 5'(b);
      e.sum = es[b];
      e.cnt = ec[b];
      e.last = (b == 31);
      exp_q.push_back(e);
    end
  endtask

  task automatic grp(input logic [4:0] c0, input logic [4:0] c1,
                     input logic [4:0] c2, input logic [4:0] c3,
                     input logic [3:0] u, input int a, input int b,
                     input int cc, input int d, input logic e,
                     input logic dn);
    cate = {c3, c2, c1, c0};
    b_use = u;
    s41 = 7'(a);
    s31 = 7'(b);
    s21 = 6'(cc);
    s11 = 5'(d);
    in_valid = 1'b1;
    en = e;
    done = dn;
    step();
    in_valid = 1'b0;
    en = 1'b1;
    done = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic drain(input bit tog);
    int k;
    k = 0;
    out_ready = 1'b1;
    @(negedge clk);
    chk("drain_valid", out_valid, 1);
    chk("drain_idx0", out_idx, 0);
    while (busy && k < 200) begin
      step();
      k++;
      out_ready = tog ? (k % 3 == 0) : 1'b1;
    end
    out_ready = 1'b0;
    chk("drain_bound", k < 200, 1);
    if (!tog) chk("drain_len", k, 32);
    chk("drain_busy", busy, 0);
    chk("drain_valid_off", out_valid, 0);
    chk("sb_empty", exp_q.size(), 0);
  endtask

  // Monitor: pops on each handshake, checks held output during stalls.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!arst && out_valid && out_ready) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL beat_unexpected idx=%0d", out_idx);
        end else begin
          e = exp_q.pop_front();
          if (out_idx !== e.idx || out_sum !== 8'(e.sum) ||
              out_cnt !== 12'(e.cnt) || out_last !== e.last) begin
            bad++;
            $display("FAIL beat idx=%0d/%0d sum=%0d/%0d cnt=%0d/%0d last=%0b/%0b",
                     out_idx, e.idx, out_sum, e.sum, out_cnt, e.cnt,
                     out_last, e.last);
          end
        end
      end else if (!arst && !start && out_valid && exp_q.size() > 0) begin
        e = exp_q[0];
        total++;
        if (out_idx !== e.idx || out_sum !== 8'(e.sum) ||
            out_cnt !== 12'(e.cnt)) begin
          bad++;
          $display("FAIL stall idx=%0d/%0d sum=%0d/%0d cnt=%0d/%0d",
                   out_idx, e.idx, out_sum, e.sum, out_cnt, e.cnt);
        end
      end
    end
  end

  initial begin
    int k;
    arst = 1'b1;
    en = 1'b1;
    start = 1'b0;
    done = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    cate = '0;
    b_use = '0;
    s41 = '0;
    s31 = '0;
    s21 = '0;
    s11 = '0;
    step();
    step();
    arst = 1'b0;
    @(negedge clk);
    chk("rst_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_idx", out_idx, 0);
    chk("rst_sum", out_sum, 0);
    chk("rst_cnt", out_cnt, 0);
    chk("rst_last", out_last, 0);

    // single category, all four pixels
    step();
    do_start();
    chk("start_busy", busy, 1);
    clr_exp();
    es[3] = 10; ec[3] = 4;
    push_drain();
    grp(3, 3, 3, 3, 4'b1111, 10, 7, 4, 2, 1'b1, 1'b0);
    done = 1'b1;
    step();
    done = 1'b0;
    drain(1'b0);

    // done and in_valid ignored in IDLE
    grp(0, 0, 0, 0, 4'b1111, 9, 0, 0, 0, 1'b1, 1'b1);
    @(negedge clk);
    chk("idle_busy", busy, 0);
    chk("idle_sum0", out_sum, 0);
    chk("idle_cnt0", out_cnt, 0);

    // mixed leaders, masks, en gating, group with done
    step();
    do_start();
    clr_exp();
    es[1] = -5; ec[1] = 2;
    es[2] = 6;  ec[2] = 1;
    es[4] = -2; ec[4] = 1;
    es[7] = 3;  ec[7] = 1;
    es[9] = -4; ec[9] = 1;
    push_drain();
    grp(1, 2, 1, 4, 4'b1111, -5, 6, 3, -2, 1'b1, 1'b0);
    grp(1, 1, 1, 1, 4'b0000, 20, 1, 1, 1, 1'b1, 1'b0);
    grp(6, 6, 6, 6, 4'b1111, 9, 1, 1, 1, 1'b0, 1'b0);
    grp(7, 7, 9, 9, 4'b0101, 3, 0, -4, 0, 1'b1, 1'b1);
    drain(1'b1);

    // positive saturation
    do_start();
    clr_exp();
    es[5] = 127; ec[5] = 44;
    push_drain();
    for (int i = 0; i < 11; i++) begin
      grp(5, 5, 5, 5, 4'b1111, 12, 0, 0, 0, 1'b1, i == 10);
    end
    drain(1'b0);

    // negative saturation
    do_start();
    clr_exp();
    es[5] = -128; ec[5] = 36;
    push_drain();
    for (int i = 0; i < 9; i++) begin
      grp(5, 5, 5, 5, 4'b1111, -16, 0, 0, 0, 1'b1, i == 8);
    end
    drain(1'b0);

    // async reset in the middle of a drain
    do_start();
    clr_exp();
    es[0] = 5; ec[0] = 4;
    push_drain();
    grp(0, 0, 0, 0, 4'b1111, 5, 0, 0, 0, 1'b1, 1'b1);
    out_ready = 1'b1;
    k = 0;
    while (out_idx != 5'd12 && k < 100) begin
      step();
      k++;
    end
    chk("arst_reach12", out_idx, 12);
    arst = 1'b1;
    #1;
    chk("arst_valid", out_valid, 0);
    chk("arst_busy", busy, 0);
    chk("arst_idx", out_idx, 0);
    chk("arst_sum0", out_sum, 0);
    chk("arst_cnt0", out_cnt, 0);
    exp_q.delete();
    out_ready = 1'b0;
    step();
    arst = 1'b0;
    step();

    // start aborts a drain and clears bins
    do_start();
    clr_exp();
    es[0] = 5; ec[0] = 4;
    push_drain();
    grp(0, 0, 0, 0, 4'b1111, 5, 0, 0, 0, 1'b1, 1'b1);
    out_ready = 1'b1;
    k = 0;
    while (out_idx != 5'd5 && k < 100) begin
      step();
      k++;
    end
    chk("abort_reach5", out_idx, 5);
    out_ready = 1'b0;
    start = 1'b1;
    exp_q.delete();
    step();
    start = 1'b0;
    chk("abort_valid", out_valid, 0);
    chk("abort_busy", busy, 1);
    chk("abort_idx", out_idx, 0);
    chk("abort_sum0", out_sum, 0);
    chk("abort_cnt0", out_cnt, 0);
    clr_exp();
    es[2] = 1; ec[2] = 4;
    push_drain();
    grp(2, 2, 2, 2, 4'b1111, 1, 0, 0, 0, 1'b1, 1'b1);
    drain(1'b0);

    step();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
